aes_encrypt_scheduler: RTL and testbench
========================================

Name: aes_encrypt_scheduler

Overview:
- Sequences a shared, purely combinational AES-128 round datapath (AddRoundKey, full encrypt round, last encrypt round) over Nr+1 clock cycles per block.
- Owns the 128-bit state register and the round counter, and selects the round key from the expanded key bus.
- Arbitrates two block requesters round-robin and returns each ciphertext tagged with the requester id through a valid/ready output handshake.
- Sits between the KeyExpansion output, the round modules and the two client ports.

Parameters:
- Nk, 4, key length in 32-bit words; carried for consistency, only 4 supported.
- Nr, 10, number of rounds; round counter is 4 bits, so Nr must be ≤ 14.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester block valid
- req_data0  input  128  plaintext, requester 0
- req_data1  input  128  plaintext, requester 1
- req_ready  output  2  per-requester accept (one-hot or zero)
- allKeys  input  (Nr+1)*128  expanded keys, round k at bits [128k+127:128k]
- dp_state  output  128  current state register, to the round modules
- dp_key  output  128  selected round key, to the round modules
- dp_add_key_result  input  128  AddRoundKey(dp_state, dp_key)
- dp_round_result  input  128  EncryptRound(dp_state, dp_key)
- dp_last_result  input  128  LastEncryptRound(dp_state, dp_key)
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  128  ciphertext (equals dp_state)
- out_id  output  1  requester that owns out_data
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0) forces:
  - fsm=IDLE, state reg=0, rnd=0.
  - out_valid=0, out_id=0, busy=0, req_ready=0.
  - Round-robin pointer set so requester 0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational and one-hot for the granted requester.
  - With a single requester valid, that requester is granted.
  - With both valid, the requester not granted last is granted.
  - With none valid, req_ready=0.
  - On accept (req_valid[i] & req_ready[i] at an edge): state<=req_data_i, out_id<=i, pointer<=i, rnd<=0, fsm<=RUN.
- RUN:
  - dp_key = allKeys[128*rnd +: 128] and req_ready=0.
  - rnd==0: state<=dp_add_key_result.
  - 1≤rnd≤Nr-1: state<=dp_round_result.
  - rnd==Nr: state<=dp_last_result, fsm<=DONE.
  - rnd increments by 1 every RUN cycle and never wraps within a block.
- DONE:
  - out_valid=1; out_data and out_id are held stable until the handshake.
  - On out_valid & out_ready: fsm<=IDLE, rnd<=0. No new accept in the same cycle, so a new accept is possible one cycle later at the earliest.
- Latency: accept edge at cycle t → Nr+1 RUN cycles (t+1 .. t+Nr+1) → out_valid high from cycle t+Nr+2. For Nr=10, that is 12 cycles.
- Throughput: one block per Nr+3 cycles when out_ready is held high.
- Outside DONE: out_valid=0. dp_key selects allKeys[127:0] in IDLE and DONE.
- allKeys must stay stable while busy=1; the block does not latch keys.
- A requester changing data or dropping valid without being accepted is not an error; nothing is captured.
- Reset mid-RUN or mid-DONE: the block is abandoned immediately, no output is produced, and the block returns to IDLE with the reset values above.
- out_ready asserted outside DONE is ignored.

Test Plan:
- Single block, FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (expanded), requester 0 sends 00112233445566778899aabbccddeeff, out_ready=1 → out_valid 12 cycles after accept, out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0, single-cycle out_valid.
- Tie arbitration: both valid continuously, out_ready=1 → grants alternate 0,1,0,1 and out_id follows; each returns the correct ciphertext (same plaintext gives same ciphertext); accepts are spaced 13 cycles apart.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_valid, out_data and out_id are held constant, req_ready stays 0 and busy stays 1; releasing out_ready → IDLE next cycle, then a new accept.
- Intermediate check: at rnd=1 the state reg equals data XOR key0 = 00102030405060708090a0b0c0d0e0f0; dp_key sequence over RUN is allKeys round 0..10 in order.
- Reset mid-operation: pull rst_n low at rnd=5 → out_valid=0, busy=0 and state reg=0 immediately (asynchronously); after release, requester 1 alone valid → it is granted and completes correctly.
- Idle behaviour: no req_valid for 50 cycles → req_ready=0, out_valid=0, busy=0, state reg unchanged.

Source files
------------

// File: rtl/aes_encrypt_scheduler.sv
// ---------------------------------------------------------------------------
// aes_encrypt_scheduler
//
// Sequences an external, purely combinational AES-128 round datapath over
// Nr+1 cycles per block. The block owns the 128-bit state register and the
// round counter, and it selects the round key from the expanded key bus.
// Two requesters are arbitrated round-robin. Each ciphertext is returned with
// the id of its requester through a valid/ready handshake.
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   req_valid[1:0]      : per-requester plaintext valid
//   req_data0/1         : plaintext of requester 0 / 1
//   req_ready[1:0]      : per-requester accept (one-hot or zero, IDLE only)
//   allKeys             : expanded keys, round k at [128k+127:128k]
//   dp_state, dp_key    : operands driven to the round datapath
//   dp_*_result         : AddRoundKey / EncryptRound / LastEncryptRound results
//   out_valid/out_ready : ciphertext handshake
//   out_data, out_id    : ciphertext and owning requester
//   busy                : high while a block is in RUN or DONE
// ---------------------------------------------------------------------------
module aes_encrypt_scheduler #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [127:0]            req_data0,
  input  logic [127:0]            req_data1,
  output logic [1:0]              req_ready,
  input  logic [(Nr+1)*128-1:0]   allKeys,
  output logic [127:0]            dp_state,
  output logic [127:0]            dp_key,
  input  logic [127:0]            dp_add_key_result,
  input  logic [127:0]            dp_round_result,
  input  logic [127:0]            dp_last_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data,
  output logic                    out_id,
  output logic                    busy
);

  // Only AES-128 is supported, and the round counter is 4 bits wide.
  if (Nk != 4 || Nr < 1 || Nr > 14) begin : g_cfg_check
    $error("aes_encrypt_scheduler: unsupported Nk/Nr combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] RND_LAST = 4'(Nr);

  state_e       r_fsm;
  state_e       w_fsm_next;
  logic [127:0] r_state;
  logic [3:0]   r_rnd;
  logic         r_id;
  logic         r_ptr;      // requester granted most recently
  logic [1:0]   w_grant;
  logic [3:0]   w_key_idx;
  logic [127:0] w_key;

  // Round-robin grant. This is only active in IDLE and outside reset. On a
  // tie, the requester that was not granted last wins.
  always_comb begin
    w_grant = 2'b00;
    if (rst_n && (r_fsm == S_IDLE)) begin
      if (req_valid == 2'b11) begin
        w_grant = r_ptr ? 2'b01 : 2'b10;
      end else begin
        w_grant = req_valid;
      end
    end else begin
      w_grant = 2'b00;
    end
  end

  // Round-key select. Outside RUN the key index falls back to round 0.
  always_comb begin
    w_key_idx = 4'd0;
    if ((r_fsm == S_RUN) && (r_rnd <= RND_LAST)) begin
      w_key_idx = r_rnd;
    end else begin
      w_key_idx = 4'd0;
    end
    w_key = allKeys[{w_key_idx, 7'd0} +: 128];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE: begin
        if (|w_grant) begin
          w_fsm_next = S_RUN;
        end else begin
          w_fsm_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_rnd == RND_LAST) begin
          w_fsm_next = S_DONE;
        end else begin
          w_fsm_next = S_RUN;
        end
      end
      S_DONE: begin
        // Returning to IDLE without granting blocks a same-cycle accept.
        if (out_ready) begin
          w_fsm_next = S_IDLE;
        end else begin
          w_fsm_next = S_DONE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // State register, round counter, owner id and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= 128'd0;
      r_rnd   <= 4'd0;
      r_id    <= 1'b0;
      r_ptr   <= 1'b1;  // requester 0 wins the first tie
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (|w_grant) begin
            r_state <= w_grant[1] ? req_data1 : req_data0;
            r_id    <= w_grant[1];
            r_ptr   <= w_grant[1];
            r_rnd   <= 4'd0;
          end else begin
            r_rnd   <= 4'd0;
          end
        end
        S_RUN: begin
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == 4'd0) begin
            r_state <= dp_add_key_result;
          end else if (r_rnd == RND_LAST) begin
            r_state <= dp_last_result;
          end else begin
            r_state <= dp_round_result;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_rnd <= 4'd0;
          end else begin
            r_rnd <= r_rnd;
          end
        end
        default: r_rnd <= 4'd0;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    req_ready = w_grant;
    out_valid = (r_fsm == S_DONE);
    busy      = (r_fsm == S_RUN) || (r_fsm == S_DONE);
    out_data  = r_state;
    out_id    = r_id;
    dp_state  = r_state;
    dp_key    = w_key;
  end

endmodule

// File: tb/tb_aes_encrypt_scheduler.sv
module tb_aes_encrypt_scheduler;
  localparam int NR = 10;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [127:0]         req_data0;
  logic [127:0]         req_data1;
  logic [1:0]           req_ready;
  logic [(NR+1)*128-1:0] all_keys;
  logic [127:0]         dp_state;
  logic [127:0]         dp_key;
  logic [127:0]         dp_add_key_result;
  logic [127:0]         dp_round_result;
  logic [127:0]         dp_last_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;
  logic                 out_id;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [127:0] rk [0:NR];
  logic         last_id;
  logic [127:0] last_ct;

  aes_encrypt_scheduler #(.Nk(4), .Nr(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .allKeys(all_keys),
    .dp_state(dp_state), .dp_key(dp_key),
    .dp_add_key_result(dp_add_key_result), .dp_round_result(dp_round_result),
    .dp_last_result(dp_last_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, r;
    a = a_in; b = b_in; r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p = x; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin   // x^254 = x^-1 in GF(2^8), 0 maps to 0
      p = gmul(p, p);
      inv = gmul(inv, p);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte (r,c) of the state sits at FIPS byte index r+4c, MSB first.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [0:3];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                                ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < NR; r++) s = mix(sub_shift(s)) ^ rk[r];
    return sub_shift(s) ^ rk[NR];
  endfunction

  // Combinational round datapath seen by the scheduler.
  assign dp_add_key_result = dp_state ^ dp_key;
  assign dp_round_result   = mix(sub_shift(dp_state)) ^ dp_key;
  assign dp_last_result    = sub_shift(dp_state) ^ dp_key;

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:4*(NR+1)-1];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++) begin
      rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      all_keys[128*k +: 128] = rk[k];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers a request, follows the block through every RUN cycle and checks
  // the DONE outputs. Returns early at round stop_rnd if that is <= 10.
  task automatic run_one(input logic [1:0] vmask, input logic [127:0] d0,
                         input logic [127:0] d1, input bit keep, input int stop_rnd);
    logic [1:0]   exp_grant;
    logic         exp_id;
    logic [127:0] pt;
    req_data0 = d0; req_data1 = d1; req_valid = vmask;
    #1;
    exp_grant = (vmask == 2'b11) ? (last_id ? 2'b01 : 2'b10) : vmask;
    chk("grant", {126'd0, req_ready}, {126'd0, exp_grant});
    exp_id  = exp_grant[1];
    pt      = exp_id ? d1 : d0;
    last_ct = aes_ref(pt);
    @(posedge clk);
    last_id = exp_id;
    for (int n = 0; n <= NR; n++) begin
      @(negedge clk);
      if (n == 0) acc_cyc = cyc;
      if (!keep && n == 0) req_valid = 2'b00;
      if (n == stop_rnd) return;
      chk("run_key", dp_key, rk[n]);
      chk("run_busy", {127'd0, busy}, 128'd1);
      chk("run_valid", {127'd0, out_valid}, 128'd0);
      chk("run_ready", {126'd0, req_ready}, 128'd0);
      if (n == 1) chk("rnd1_state", dp_state, pt ^ rk[0]);
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_valid", {127'd0, out_valid}, 128'd1);
    chk("done_data", out_data, last_ct);
    chk("done_id", {127'd0, out_id}, {127'd0, exp_id});
    chk("done_ready", {126'd0, req_ready}, 128'd0);
  endtask

  // Completes the output handshake and checks the return to IDLE.
  task automatic finish_block();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", {127'd0, out_valid}, 128'd0);
    chk("post_busy", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    logic [127:0] pt;
    logic [1:0]   vm;
    int           prev_acc;
    int           hold;

    rst_n = 1'b0; req_valid = 2'b00; req_data0 = '0; req_data1 = '0; out_ready = 1'b0;
    last_id = 1'b1; last_ct = '0;
    expand(128'h000102030405060708090a0b0c0d0e0f);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ready", {126'd0, req_ready}, 128'd0);
    chk("rst_state", dp_state, 128'd0);
    chk("rst_id", {127'd0, out_id}, 128'd0);
    chk("rst_key", dp_key, rk[0]);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 single block from requester 0.
    out_ready = 1'b1;
    run_one(2'b01, 128'h00112233445566778899aabbccddeeff, '0, 1'b0, 99);
    chk("fips_ct", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    finish_block();

    // Idle: nothing offered, state register holds the last ciphertext.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_ready", {126'd0, req_ready}, 128'd0);
      chk("idle_valid", {127'd0, out_valid}, 128'd0);
      chk("idle_busy", {127'd0, busy}, 128'd0);
      chk("idle_state", dp_state, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    end

    // Backpressure with a new random key.
    expand(rnd128());
    out_ready = 1'b0;
    run_one(2'b10, rnd128(), rnd128(), 1'b0, 99);
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_data", out_data, last_ct);
      chk("bp_id", {127'd0, out_id}, 128'd1);
      chk("bp_ready", {126'd0, req_ready}, 128'd0);
      chk("bp_busy", {127'd0, busy}, 128'd1);
    end
    finish_block();

    // Reset in the middle of a block at round 5.
    run_one(2'b01, rnd128(), rnd128(), 1'b0, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_state", dp_state, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_id = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    run_one(2'b10, rnd128(), rnd128(), 1'b0, 99);
    finish_block();

    // Tie arbitration: both valid continuously, same plaintext on both.
    pt = rnd128();
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      run_one(2'b11, pt, pt, 1'b1, 99);
      chk("tie_id", {127'd0, out_id}, {127'd0, (i % 2 == 1) ? 1'b1 : 1'b0});
      if (i > 0) chk("tie_spacing", 128'(acc_cyc - prev_acc), 128'd13);
      prev_acc = acc_cyc;
      finish_block();
    end
    req_valid = 2'b00;

    // Randomized requests, data and consumer stalls.
    for (int i = 0; i < 8; i++) begin
      vm = 2'($urandom_range(1, 3));
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      run_one(vm, rnd128(), rnd128(), 1'b0, 99);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        chk("rand_hold_data", out_data, last_ct);
        chk("rand_hold_valid", {127'd0, out_valid}, 128'd1);
      end
      finish_block();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
